stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl_pkg.sv | 38 +++
 rtl/stopwatch_ctrl_if.sv | 22 ++
 rtl/stopwatch_ctrl_bcd_time_counter.sv | 70 +++++++
 rtl/stopwatch_ctrl.sv | 74 +++++++
 4 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared encodings for the stopwatch controller: FSM state codes,
// divider-enable codes and the BCD digit limits used by the time counter.
package stopwatch_pkg;

   // FSM state encodings (also driven directly on the state output)
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;
   localparam logic [1:0] ST_LAP   = 2'b11;

   // Divider control codes
   localparam logic [1:0] EN_IDLE  = 2'b00;
   localparam logic [1:0] EN_COUNT = 2'b01;
   localparam logic [1:0] EN_HOLD  = 2'b10;

   // Highest legal value of a units digit and of the seconds-tens digit
   localparam logic [3:0] BCD_MAX_U = 4'd9;
   localparam logic [3:0] BCD_MAX_T = 4'd5;

   typedef logic [23:0] bcd_time_t;

   // Digit order from LSB: cs_u, cs_t, sec_u, sec_t; only sec_t stops at 5
   function automatic logic [3:0] digit_limit(input int idx);
      return (idx == 3) ? BCD_MAX_T : BCD_MAX_U;
   endfunction

   // Divider control follows the state register alone
   function automatic logic [1:0] en_decode(input logic [1:0] st);
      logic [1:0] en;
      case (st)
         ST_RUN, ST_LAP: en = EN_COUNT;
         ST_PAUSE:       en = EN_HOLD;
         default:        en = EN_IDLE;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control/status bundle between the stopwatch controller and its user.
interface stopwatch_ctrl_if;
   logic        start_stop;
   logic        lap_clear;
   logic        tick;
   logic [1:0]  en;
   logic [1:0]  state;
   logic [23:0] disp_bcd;
   logic        ovf;

   // Driver of the pulses, observer of the status
   modport master (
      output start_stop, lap_clear, tick,
      input  en, state, disp_bcd, ovf
   );

   // The controller itself
   modport slave (
      input  start_stop, lap_clear, tick,
      output en, state, disp_bcd, ovf
   );
endinterface

// File: rtl/stopwatch_ctrl_bcd_time_counter.sv
// Cascaded BCD time counter MM:SS.CC. Every carry is resolved in the same
// cycle; wrap pulses (combinationally) on the increment that rolls
// MAX_MIN:59.99 back to zero.
module bcd_time_counter
   import stopwatch_pkg::*;
#(
   parameter int MAX_MIN = 59
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      inc_i,
   input  logic      clr_i,
   output bcd_time_t time_bcd_o,
   output logic      wrap_o
);

   localparam logic [3:0] MAX_MIN_T = 4'(MAX_MIN / 10);
   localparam logic [3:0] MAX_MIN_U = 4'(MAX_MIN % 10);

   logic [3:0][3:0] low_digits;  // cs_u, cs_t, sec_u, sec_t
   logic [4:0]      carry;       // carry[i] = increment request into digit i
   logic [3:0]      min_u_q;
   logic [3:0]      min_t_q;

   assign carry[0] = inc_i;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         logic [3:0] digit_q;

         assign low_digits[gi] = digit_q;
         assign carry[gi+1]    = carry[gi] && (digit_q == digit_limit(gi));

         // Sub-minute digit: roll to zero at its limit, else count up
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               digit_q <= 4'd0;
            end else if (clr_i) begin
               digit_q <= 4'd0;
            end else if (carry[gi]) begin
               digit_q <= (digit_q == digit_limit(gi)) ? 4'd0 : digit_q + 4'd1;
            end
         end
      end
   endgenerate

   assign wrap_o = carry[4] && (min_t_q == MAX_MIN_T) && (min_u_q == MAX_MIN_U);

   // Minutes: two BCD digits, wrapping to 00 after MAX_MIN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         min_u_q <= 4'd0;
         min_t_q <= 4'd0;
      end else if (clr_i || wrap_o) begin
         min_u_q <= 4'd0;
         min_t_q <= 4'd0;
      end else if (carry[4]) begin
         if (min_u_q == BCD_MAX_U) begin
            min_u_q <= 4'd0;
            min_t_q <= min_t_q + 4'd1;
         end else begin
            min_u_q <= min_u_q + 4'd1;
         end
      end
   end

   assign time_bcd_o = {min_t_q, min_u_q, low_digits[3], low_digits[2],
                        low_digits[1], low_digits[0]};

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/lap/idle FSM, lap hold register, sticky
// overflow flag and the display mux around a BCD time counter.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int MAX_MIN = 59
) (
   input  logic            clk,
   input  logic            reset,
   stopwatch_ctrl_if.slave bus
);

   logic [1:0] state_q, state_d;
   bcd_time_t  lap_q;
   logic       ovf_q;
   bcd_time_t  live_time;
   logic       wrap;
   logic       inc;
   logic       clr;
   logic       lap_take;
   logic       lc_only;

   // start_stop has priority; lap_clear only acts when start_stop is low
   assign lc_only  = bus.lap_clear && !bus.start_stop;
   assign inc      = bus.tick && ((state_q == ST_RUN) || (state_q == ST_LAP));
   assign clr      = (state_q == ST_PAUSE) && lc_only;
   assign lap_take = (state_q == ST_RUN) && lc_only;

   bcd_time_counter #(
      .MAX_MIN (MAX_MIN)
   ) u_counter (
      .clk        (clk),
      .reset      (reset),
      .inc_i      (inc),
      .clr_i      (clr),
      .time_bcd_o (live_time),
      .wrap_o     (wrap)
   );

   // Next-state logic for the run/pause/lap/idle FSM
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.start_stop) state_d = ST_RUN;
         ST_RUN:   if (bus.start_stop) state_d = ST_PAUSE;
                   else if (bus.lap_clear) state_d = ST_LAP;
         ST_LAP:   if (bus.start_stop) state_d = ST_PAUSE;
                   else if (bus.lap_clear) state_d = ST_RUN;
         ST_PAUSE: if (bus.start_stop) state_d = ST_RUN;
                   else if (bus.lap_clear) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State, lap snapshot and sticky overflow registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         lap_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (lap_take) lap_q <= live_time;
         if (clr) ovf_q <= 1'b0;
         else if (wrap) ovf_q <= 1'b1;
      end
   end

   assign bus.state    = state_q;
   assign bus.en       = en_decode(state_q);
   assign bus.ovf      = ovf_q;
   assign bus.disp_bcd = (state_q == ST_LAP) ? lap_q : live_time;

endmodule
